hdmi_qsys_irq_ctrl: RTL and testbench
=====================================

// Module: hdmi_qsys_irq_ctrl
// PURPOSE
//  Interrupt aggregation stage directly downstream of the system interval timer and other
//  level-IRQ peripherals in the HDMI Qsys subsystem.
//  - Edge-captures each source into a pending bit, masks it, and drives one CPU irq.
//  - Reports the highest-priority active source, overruns (missed ticks) and a tick count.
//  - Host access is a 16-bit Avalon-MM slave with a 3-bit address; readdata is registered.
// PARAMETERS
//  NUM_IRQ    4   number of irq_in sources, 1..16; source 0 = timer, lowest index = highest priority
//  CNT_WIDTH  16  width of the source-0 event counter, 1..16
// PORTS
//  clk         in   1         system clock; all logic on rising edge
//  reset       in   1         asynchronous, active-high reset
//  irq_in      in   NUM_IRQ   level-high interrupt requests (e.g. timer irq on bit 0)
//  address     in   3         Avalon-MM register word address
//  chipselect  in   1         slave select
//  write_n     in   1         active-low write strobe
//  writedata   in   16        write data
//  readdata    out  16        registered read data
//  irq         out  1         registered CPU interrupt request
// BEHAVIOUR
//  Reset: readdata=0, irq=0, pending=0, enable=0, overrun=0, count=0, irq_in_d=0.
//  Edge detect: rise[i] = src[i] & ~src_d[i]; src_d[i] registered every cycle.
//   A level held high does not re-trigger.
//  pending[i]: set on rise[i]; cleared by a write of 1 to bit i at addr 0 (W1C).
//   Set and clear in the same cycle: set wins, so pending stays 1.
//  overrun[i]: sticky; set on rise[i] while pending[i]==1 and that pending bit is not
//   cleared in the same cycle. Cleared by W1C at addr 3.
//  count: increments on rise[0]; saturates at all-ones, never wraps.
//   Any write to addr 4 loads 0. A write and rise[0] in the same cycle gives 0.
//  irq: registered value of |(pending & enable); asserts 1 cycle after pending is set
//   with enable high. irq_in rise to irq high = 2 cycles.
//  Active vector: valid = |(pending & enable); index = lowest i with pending[i]&enable[i],
//   or 0 when valid=0.
//  Register map; unused high bits read 0; addresses 5..7 read 0 and ignore writes:
//   0 PENDING  R/W1C  [NUM_IRQ-1:0]
//   1 ENABLE   R/W    [NUM_IRQ-1:0]
//   2 ACTIVE   RO     [15]=valid, [3:0]=index
//   3 OVERRUN  R/W1C  [NUM_IRQ-1:0]
//   4 COUNT    R/Wclr [CNT_WIDTH-1:0]
//  Write strobe = chipselect & ~write_n & address match. Writes take effect on the next edge.
//  readdata is registered every cycle from the address mux, independent of chipselect.
//   Read latency = 1 cycle.
//  A read of PENDING/ACTIVE returns the state before any same-cycle update.
//  Reset asserted mid-operation clears all state at once.
//   After deassert, a source already high is seen as a rising edge.
// CONFIGURATION
//  IRQ_CTRL_SYNC_EN defined: irq_in passes through a 2-flop synchronizer (reset 0) before
//   edge detect, for asynchronous sources. irq_in rise to irq high = 4 cycles.
//  IRQ_CTRL_SYNC_EN undefined: irq_in feeds edge detect directly. Sources must be
//   synchronous to clk. Latency = 2 cycles.
//  Register map and all other behaviour are identical in both builds.
// TESTING
//  T1 reset, ENABLE=0x1, pulse irq_in[0] high at cycle N -> PENDING=0x1, irq=1 at N+2
//     (N+4 with SYNC_EN); ACTIVE=0x8000; COUNT=1.
//  T2 hold irq_in[0] high 50 cycles -> COUNT=1, no overrun. Write 0x1 to addr 0
//     -> PENDING=0, irq=0 one cycle later.
//  T3 ENABLE=0xF, raise irq_in[2] then irq_in[1] -> ACTIVE=0x8001. W1C bit 1 -> ACTIVE=0x8002.
//  T4 second rise on source 0 while pending -> OVERRUN=0x1. W1C pending in the same cycle
//     as a new rise -> PENDING stays 0x1, OVERRUN unchanged.
//  T5 70000 rises on source 0 -> COUNT=0xFFFF; write addr 4 -> COUNT=0.
//  T6 assert reset mid-traffic -> all registers, readdata and irq read 0 on the next
//     cycle; an input still high after deassert sets pending again.

Source files
------------

// File: rtl/hdmi_qsys_irq_ctrl.sv
// Edge-captured, masked interrupt aggregator with a 16-bit Avalon-MM register slave; optional IRQ_CTRL_SYNC_EN input synchronizer.
// Latency: readdata 1 cycle; irq_in rise to irq high 2 cycles (4 with IRQ_CTRL_SYNC_EN).
// Backpressure: none; every access completes in one cycle and sources are never stalled.
module hdmi_qsys_irq_ctrl #(
  parameter int NUM_IRQ   = 4,
  parameter int CNT_WIDTH = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_IRQ-1:0] irq_in,
  input  logic [2:0]         address,
  input  logic               chipselect,
  input  logic               write_n,
  input  logic [15:0]        writedata,
  output logic [15:0]        readdata,
  output logic               irq
);

  logic [NUM_IRQ-1:0]   src;
  logic [NUM_IRQ-1:0]   src_d_q;
  logic [NUM_IRQ-1:0]   pending_q, pending_d;
  logic [NUM_IRQ-1:0]   enable_q, enable_d;
  logic [NUM_IRQ-1:0]   overrun_q, overrun_d;
  logic [CNT_WIDTH-1:0] count_q, count_d;
  logic [15:0]          readdata_q, readdata_d;
  logic                 irq_q;

  logic [NUM_IRQ-1:0]   rise, active, wmask, clr_pend, clr_ovr;
  logic                 wr, act_vld;
  logic [3:0]           act_idx;

`ifdef IRQ_CTRL_SYNC_EN
  logic [NUM_IRQ-1:0] sync1_q, sync2_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= irq_in;
      sync2_q <= sync1_q;
    end
  end

  assign src = sync2_q;
`else
  assign src = irq_in;
`endif

  assign rise     = src & ~src_d_q;
  assign wr       = chipselect & ~write_n;
  assign wmask    = writedata[NUM_IRQ-1:0];
  assign clr_pend = (wr && address == 3'd0) ? wmask : '0;
  assign clr_ovr  = (wr && address == 3'd3) ? wmask : '0;
  assign active   = pending_q & enable_q;
  assign act_vld  = |active;

  // Reverse scan so the lowest active index is the one left standing.
  always_comb begin
    act_idx = 4'd0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (active[i]) act_idx = 4'(i);
    end
  end

  always_comb begin
    pending_d = (pending_q & ~clr_pend) | rise;
    overrun_d = (overrun_q & ~clr_ovr) | (rise & pending_q & ~clr_pend);
    enable_d  = (wr && address == 3'd1) ? wmask : enable_q;

    count_d = count_q;
    if (wr && address == 3'd4) begin
      count_d = '0;
    end else if (rise[0] && !(&count_q)) begin
      count_d = count_q + 1'b1;
    end

    // Mux works on pre-update state, so same-cycle writes are not visible yet.
    readdata_d = 16'h0000;
    case (address)
      3'd0:    readdata_d = 16'(pending_q);
      3'd1:    readdata_d = 16'(enable_q);
      3'd2:    readdata_d = {act_vld, 11'd0, act_idx};
      3'd3:    readdata_d = 16'(overrun_q);
      3'd4:    readdata_d = 16'(count_q);
      default: readdata_d = 16'h0000;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      src_d_q    <= '0;
      pending_q  <= '0;
      enable_q   <= '0;
      overrun_q  <= '0;
      count_q    <= '0;
      readdata_q <= '0;
      irq_q      <= 1'b0;
    end else begin
      src_d_q    <= src;
      pending_q  <= pending_d;
      enable_q   <= enable_d;
      overrun_q  <= overrun_d;
      count_q    <= count_d;
      readdata_q <= readdata_d;
      irq_q      <= act_vld;
    end
  end

  assign readdata = readdata_q;
  assign irq      = irq_q;

endmodule

// File: tb/tb_hdmi_qsys_irq_ctrl.sv
// Directed bench for hdmi_qsys_irq_ctrl: per-cycle vector table plus hand sequences for multi-cycle corners.
module tb_hdmi_qsys_irq_ctrl;

  localparam int NUM_IRQ   = 4;
  localparam int CNT_WIDTH = 10;

  logic               clk = 1'b0;
  logic               reset;
  logic [NUM_IRQ-1:0] irq_in;
  logic [2:0]         address;
  logic               chipselect;
  logic               write_n;
  logic [15:0]        writedata;
  logic [15:0]        readdata;
  logic               irq;

  int errors = 0;
  int checks = 0;

  hdmi_qsys_irq_ctrl #(.NUM_IRQ(NUM_IRQ), .CNT_WIDTH(CNT_WIDTH)) dut (
    .clk        (clk),
    .reset      (reset),
    .irq_in     (irq_in),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .irq        (irq)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  src;
    logic        cs;
    logic        wn;
    logic [2:0]  addr;
    logic [15:0] wd;
    logic [15:0] exp_rd;
    logic        exp_irq;
  } vec_t;

  vec_t vecs[22];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%04h expected 0x%04h", name, act, exp);
    end
  endtask

  task automatic wr(input logic [2:0] a, input logic [15:0] d);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    tick();
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  task automatic rd(input logic [2:0] a, output logic [15:0] d);
    address    = a;
    chipselect = 1'b1;
    write_n    = 1'b1;
    tick();
    d          = readdata;
    chipselect = 1'b0;
  endtask

  task automatic pulse0();
    irq_in[0] = 1'b1;
    tick();
    irq_in[0] = 1'b0;
    tick();
  endtask

  logic [15:0] r;

  initial begin
    // exp_rd is the register selected during that cycle, before the edge updates it;
    // exp_irq is |(pending & enable) as it stood before the edge.
    vecs[0]  = '{4'h0, 1'b1, 1'b1, 3'd1, 16'h0000, 16'h0000, 1'b0};
    vecs[1]  = '{4'h0, 1'b1, 1'b0, 3'd1, 16'h0001, 16'h0000, 1'b0};
    vecs[2]  = '{4'h1, 1'b1, 1'b1, 3'd0, 16'h0000, 16'h0000, 1'b0};
    vecs[3]  = '{4'h0, 1'b1, 1'b1, 3'd0, 16'h0000, 16'h0001, 1'b1};
    vecs[4]  = '{4'h0, 1'b1, 1'b1, 3'd2, 16'h0000, 16'h8000, 1'b1};
    vecs[5]  = '{4'h0, 1'b1, 1'b1, 3'd4, 16'h0000, 16'h0001, 1'b1};
    vecs[6]  = '{4'h0, 1'b1, 1'b1, 3'd3, 16'h0000, 16'h0000, 1'b1};
    vecs[7]  = '{4'h0, 1'b1, 1'b0, 3'd1, 16'h000F, 16'h0001, 1'b1};
    vecs[8]  = '{4'h4, 1'b1, 1'b1, 3'd2, 16'h0000, 16'h8000, 1'b1};
    vecs[9]  = '{4'h6, 1'b1, 1'b1, 3'd2, 16'h0000, 16'h8000, 1'b1};
    vecs[10] = '{4'h6, 1'b1, 1'b0, 3'd0, 16'h0001, 16'h0007, 1'b1};
    vecs[11] = '{4'h6, 1'b1, 1'b1, 3'd2, 16'h0000, 16'h8001, 1'b1};
    vecs[12] = '{4'h6, 1'b1, 1'b0, 3'd0, 16'h0002, 16'h0006, 1'b1};
    vecs[13] = '{4'h6, 1'b1, 1'b1, 3'd2, 16'h0000, 16'h8002, 1'b1};
    vecs[14] = '{4'h6, 1'b1, 1'b0, 3'd0, 16'h0004, 16'h0004, 1'b1};
    vecs[15] = '{4'h6, 1'b1, 1'b1, 3'd0, 16'h0000, 16'h0000, 1'b0};
    vecs[16] = '{4'h0, 1'b1, 1'b1, 3'd5, 16'h0000, 16'h0000, 1'b0};
    vecs[17] = '{4'h0, 1'b1, 1'b0, 3'd5, 16'hFFFF, 16'h0000, 1'b0};
    vecs[18] = '{4'h0, 1'b1, 1'b1, 3'd1, 16'h0000, 16'h000F, 1'b0};
    vecs[19] = '{4'h0, 1'b0, 1'b1, 3'd1, 16'h0000, 16'h000F, 1'b0};
    vecs[20] = '{4'h0, 1'b0, 1'b0, 3'd1, 16'h0000, 16'h000F, 1'b0};
    vecs[21] = '{4'h0, 1'b1, 1'b1, 3'd1, 16'h0000, 16'h000F, 1'b0};

    reset      = 1'b1;
    irq_in     = '0;
    address    = 3'd0;
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = 16'h0000;
    tick();
    tick();
    check("reset_readdata", readdata, 16'h0000);
    check("reset_irq", {15'd0, irq}, 16'h0000);
    reset = 1'b0;

    for (int i = 0; i < 22; i++) begin
      irq_in     = vecs[i].src;
      chipselect = vecs[i].cs;
      write_n    = vecs[i].wn;
      address    = vecs[i].addr;
      writedata  = vecs[i].wd;
      tick();
      check($sformatf("vec%0d_readdata", i), readdata, vecs[i].exp_rd);
      check($sformatf("vec%0d_irq", i), {15'd0, irq}, {15'd0, vecs[i].exp_irq});
    end
    chipselect = 1'b0;
    write_n    = 1'b1;
    irq_in     = '0;

    // Held level counts once and never overruns; W1C drops irq one cycle later.
    wr(3'd4, 16'h0000);
    irq_in[0] = 1'b1;
    repeat (50) tick();
    rd(3'd4, r); check("hold_count", r, 16'h0001);
    rd(3'd3, r); check("hold_overrun", r, 16'h0000);
    check("hold_irq", {15'd0, irq}, 16'h0001);
    wr(3'd0, 16'h0001);
    check("w1c_irq_same", {15'd0, irq}, 16'h0001);
    tick();
    check("w1c_irq_next", {15'd0, irq}, 16'h0000);
    rd(3'd0, r); check("w1c_pending", r, 16'h0000);
    irq_in[0] = 1'b0;
    tick();

    // Overrun on a second rise; same-cycle clear and rise keeps pending, no overrun.
    pulse0();
    pulse0();
    rd(3'd3, r); check("overrun_set", r, 16'h0001);
    wr(3'd3, 16'h0001);
    rd(3'd3, r); check("overrun_w1c", r, 16'h0000);
    irq_in[0] = 1'b1;
    wr(3'd0, 16'h0001);
    irq_in[0] = 1'b0;
    rd(3'd0, r); check("set_wins_pending", r, 16'h0001);
    rd(3'd3, r); check("set_wins_overrun", r, 16'h0000);

    // Counter saturation and clear-beats-increment.
    wr(3'd4, 16'h0000);
    for (int i = 0; i < 1100; i++) pulse0();
    rd(3'd4, r); check("count_saturate", r, 16'h03FF);
    irq_in[0] = 1'b1;
    wr(3'd4, 16'h1234);
    irq_in[0] = 1'b0;
    rd(3'd4, r); check("count_clear_vs_rise", r, 16'h0000);
    pulse0();
    rd(3'd4, r); check("count_after_clear", r, 16'h0001);

    // Reset mid-traffic, then a source still high re-pends after release.
    check("pre_reset_irq", {15'd0, irq}, 16'h0001);
    rd(3'd1, r); check("pre_reset_enable", r, 16'h000F);
    irq_in = 4'h5;
    reset  = 1'b1;
    tick();
    check("midreset_readdata", readdata, 16'h0000);
    check("midreset_irq", {15'd0, irq}, 16'h0000);
    reset = 1'b0;
    rd(3'd0, r); check("post_reset_first_read", r, 16'h0000);
    rd(3'd0, r); check("post_reset_pending", r, 16'h0005);
    rd(3'd1, r); check("post_reset_enable", r, 16'h0000);
    rd(3'd3, r); check("post_reset_overrun", r, 16'h0000);
    rd(3'd4, r); check("post_reset_count", r, 16'h0001);
    check("post_reset_irq", {15'd0, irq}, 16'h0000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
